// File: rtl/el2_pkg.sv
// el2_pkg: shared trigger packet, tdata1 field positions, FSM states and CSR selects.
package el2_pkg;
  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } el2_trigger_pkt_t;
  localparam int TD1_DMODE = 27;
  localparam int TD1_HIT = 20;
  localparam int TD1_SELECT = 19;
  localparam int TD1_ACTION = 12;
  localparam int TD1_CHAIN = 11;
  localparam int TD1_MATCH = 7;
  localparam int TD1_M = 6;
  localparam int TD1_EXECUTE = 2;
  localparam int TD1_STORE = 1;
  localparam int TD1_LOAD = 0;
  localparam logic [31:0] TD1_TYPE = 32'h2000_0000;
  localparam logic [31:0] TD1_MASK = 32'h0818_18C7;
  typedef enum logic [1:0] {ARMED, HALT_PEND, DEBUG} trig_state_e;
  localparam logic [1:0] SEL_TSELECT = 2'd0;
  localparam logic [1:0] SEL_TDATA1 = 2'd1;
  localparam logic [1:0] SEL_TDATA2 = 2'd2;
endpackage

// File: rtl/el2_trig_reg.sv
// el2_trig_reg: one trigger's tdata1/tdata2 flops with dmode write lock and sticky hit.
module el2_trig_reg
  import el2_pkg::*;
#(
  parameter bit CHAIN_OK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_mode,
  input  logic        wr1,
  input  logic        wr2,
  input  logic        hit_set,
  input  logic [31:0] wdata,
  output logic [31:0] tdata1,
  output logic [31:0] tdata2
);
  logic        lock;
  logic [31:0] wv;
  always_comb begin
    lock = tdata1[TD1_DMODE] & ~dbg_mode;
    wv = wdata & TD1_MASK;
    wv[TD1_CHAIN] = wv[TD1_CHAIN] & CHAIN_OK;
    wv[TD1_DMODE] = wv[TD1_DMODE] & dbg_mode;
  end
  // a same-cycle hit is ORed over the freshly written value
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata1 <= '0;
      tdata2 <= '0;
    end else begin
      tdata1 <= ((wr1 & ~lock) ? wv : tdata1) | (32'(hit_set) << TD1_HIT);
      if (wr2 & ~lock) tdata2 <= wdata;
    end
  end
endmodule

// File: rtl/el2_dec_trigger_ctl.sv
// el2_dec_trigger_ctl: trigger CSR state, chain qualification and debug/breakpoint fire FSM.
module el2_dec_trigger_ctl
  import el2_pkg::*;
#(
  parameter int NTRIG = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               csr_wr_en,
  input  logic [1:0]                         csr_wr_sel,
  input  logic [31:0]                        csr_wdata,
  input  logic [1:0]                         csr_rd_sel,
  output logic [31:0]                        csr_rdata,
  input  logic                               dbg_mode,
  input  logic                               i0_commit,
  input  logic [NTRIG-1:0]                   dec_i0_trigger_match_d,
  input  logic [NTRIG-1:0]                   lsu_trigger_match_m,
  output el2_trigger_pkt_t [NTRIG-1:0]       trigger_pkt_any,
  output logic                               trig_fire_dbg,
  output logic                               trig_fire_brk,
  output logic [NTRIG-1:0]                   trig_hit_vec
);
  logic [1:0]       tselect;
  logic [31:0]      td1 [NTRIG];
  logic [31:0]      td2 [NTRIG];
  logic [NTRIG-1:0] raw, fire, act;
  logic             dbg_any, brk_any;
  trig_state_e      state, state_nxt;
  assign raw = (dec_i0_trigger_match_d & {NTRIG{i0_commit}}) | lsu_trigger_match_m;
  for (genvar i = 0; i < NTRIG; i++) begin : g_trig
    localparam int LO = i - i % 2;
    localparam int HI = LO + 1;
    logic ch;
    assign ch = td1[LO][TD1_CHAIN];
    assign fire[i] = (state == ARMED) & (ch ? raw[LO] & raw[HI] : raw[i]);
    assign act[i] = td1[ch ? HI : i][TD1_ACTION];
    el2_trig_reg #(.CHAIN_OK(i % 2 == 0)) u_reg (
      .clk      (clk),
      .rst      (rst),
      .dbg_mode (dbg_mode),
      .wr1      (csr_wr_en & (csr_wr_sel == SEL_TDATA1) & (tselect == 2'(i))),
      .wr2      (csr_wr_en & (csr_wr_sel == SEL_TDATA2) & (tselect == 2'(i))),
      .hit_set  (fire[i]),
      .wdata    (csr_wdata),
      .tdata1   (td1[i]),
      .tdata2   (td2[i])
    );
    assign trigger_pkt_any[i] = '{select: td1[i][TD1_SELECT], match: td1[i][TD1_MATCH],
                                  store: td1[i][TD1_STORE], load: td1[i][TD1_LOAD],
                                  execute: td1[i][TD1_EXECUTE], m: td1[i][TD1_M],
                                  tdata2: td2[i]};
  end
  assign dbg_any = |(fire & act);
  assign brk_any = |(fire & ~act);
  always_comb begin
    state_nxt = state;
    case (state)
      ARMED:     state_nxt = dbg_mode ? DEBUG : dbg_any ? HALT_PEND : ARMED;
      HALT_PEND: state_nxt = dbg_mode ? DEBUG : HALT_PEND;
      default:   state_nxt = dbg_mode ? DEBUG : ARMED;
    endcase
  end
  always_comb begin
    csr_rdata = csr_rd_sel == SEL_TSELECT ? {30'b0, tselect} :
                csr_rd_sel == SEL_TDATA1  ? td1[tselect] | TD1_TYPE :
                csr_rd_sel == SEL_TDATA2  ? td2[tselect] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARMED;
      tselect <= '0;
      trig_fire_dbg <= 1'b0;
      trig_fire_brk <= 1'b0;
      trig_hit_vec <= '0;
    end else begin
      state <= state_nxt;
      if (csr_wr_en && csr_wr_sel == SEL_TSELECT && csr_wdata[31:2] == '0) tselect <= csr_wdata[1:0];
      trig_fire_dbg <= dbg_any;
      trig_fire_brk <= brk_any;
      trig_hit_vec <= fire;
    end
  end
endmodule

// File: tb/tb_el2_dec_trigger_ctl.sv
// tb_el2_dec_trigger_ctl: directed plan plus random stimulus against a behavioural model.
module tb_el2_dec_trigger_ctl;
  import el2_pkg::*;
  logic clk = 0, rst = 1, csr_wr_en = 0, dbg_mode = 0, i0_commit = 0;
  logic [1:0] csr_wr_sel = 0, csr_rd_sel = 0;
  logic [31:0] csr_wdata = 0, csr_rdata;
  logic [3:0] dec = 0, lsu = 0, trig_hit_vec;
  el2_trigger_pkt_t [3:0] pkt;
  logic trig_fire_dbg, trig_fire_brk;
  int vecs = 0, errs = 0;
  bit ready = 0;
  el2_dec_trigger_ctl dut (
    .clk(clk), .rst(rst), .csr_wr_en(csr_wr_en), .csr_wr_sel(csr_wr_sel),
    .csr_wdata(csr_wdata), .csr_rd_sel(csr_rd_sel), .csr_rdata(csr_rdata),
    .dbg_mode(dbg_mode), .i0_commit(i0_commit), .dec_i0_trigger_match_d(dec),
    .lsu_trigger_match_m(lsu), .trigger_pkt_any(pkt), .trig_fire_dbg(trig_fire_dbg),
    .trig_fire_brk(trig_fire_brk), .trig_hit_vec(trig_hit_vec));
  always #5 clk = ~clk;

  // model: stored tdata1 bits (no type field), tdata2, tselect, halted/in-debug flags
  logic [31:0] md1 [4], md2 [4];
  logic [1:0] mts;
  bit mhalt, mdbg;
  logic e_dbg, e_brk;
  logic [3:0] e_hit;
  localparam logic [31:0] WMASK = (32'd1 << 27) | (32'd1 << 20) | (32'd1 << 19) | (32'd1 << 12) |
                                  (32'd1 << 11) | (32'd1 << 7) | (32'd1 << 6) | 32'd7;

  always @(posedge clk) begin
    logic [3:0] rw, fr;
    logic d, b;
    logic [31:0] v;
    bit armed, ch, locked;
    int src;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin md1[i] = 0; md2[i] = 0; end
      mts = 0; mhalt = 0; mdbg = 0; e_dbg = 0; e_brk = 0; e_hit = 0;
    end else begin
      rw = (dec & {4{i0_commit}}) | lsu;
      armed = !mhalt && !mdbg;
      fr = 0; d = 0; b = 0;
      for (int i = 0; i < 4; i++) begin
        ch = md1[i & 2][11];
        src = ch ? (i | 1) : i;
        if (armed && rw[i] && (!ch || rw[i ^ 1])) begin
          fr[i] = 1;
          if (md1[src][12]) d = 1; else b = 1;
        end
      end
      e_dbg = d; e_brk = b; e_hit = fr;
      locked = md1[mts][27] && !dbg_mode;
      if (csr_wr_en) begin
        if (csr_wr_sel == 1 && !locked) begin
          v = csr_wdata & WMASK;
          if (mts[0]) v[11] = 0;
          if (!dbg_mode) v[27] = 0;
          md1[mts] = v;
        end
        if (csr_wr_sel == 2 && !locked) md2[mts] = csr_wdata;
        if (csr_wr_sel == 0 && csr_wdata < 4) mts = csr_wdata[1:0];
      end
      for (int i = 0; i < 4; i++) if (fr[i]) md1[i][20] = 1;
      if (armed) begin
        if (dbg_mode) mdbg = 1; else if (d) mhalt = 1;
      end else if (mhalt) begin
        if (dbg_mode) begin mhalt = 0; mdbg = 1; end
      end else if (!dbg_mode) mdbg = 0;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] s);
    return s == 0 ? {30'b0, mts} : s == 1 ? (md1[mts] | 32'h2000_0000) : s == 2 ? md2[mts] : 32'h0;
  endfunction
  function automatic el2_trigger_pkt_t exp_pkt(input int i);
    return '{select: md1[i][19], match: md1[i][7], store: md1[i][1], load: md1[i][0],
             execute: md1[i][2], m: md1[i][6], tdata2: md2[i]};
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (ready) begin
    chk("rdata", 64'(csr_rdata), 64'(exp_rd(csr_rd_sel)));
    for (int i = 0; i < 4; i++) chk($sformatf("pkt%0d", i), 64'(pkt[i]), 64'(exp_pkt(i)));
    chk("fire_dbg", 64'(trig_fire_dbg), 64'(e_dbg));
    chk("fire_brk", 64'(trig_fire_brk), 64'(e_brk));
    chk("hit_vec", 64'(trig_hit_vec), 64'(e_hit));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    csr_wr_en = 1; csr_wr_sel = s; csr_wdata = d;
    tick();
    csr_wr_en = 0;
  endtask
  task automatic mt(input logic [3:0] d, input logic c, input logic [3:0] l);
    dec = d; i0_commit = c; lsu = l;
    tick();
    dec = 0; i0_commit = 0; lsu = 0;
  endtask
  task automatic rd(input string n, input logic [1:0] s, input logic [31:0] e);
    csr_rd_sel = s; #1;
    chk(n, 64'(csr_rdata), 64'(e));
  endtask

  initial begin
    tick(); ready = 1; tick();
    rst = 0;
    chk("rst_hit", 64'(trig_hit_vec), 0);
    chk("rst_pkt", 64'(pkt), 0);
    rd("rst_tsel", 0, 0);
    wr(0, 2); wr(1, 32'h0000_1044); wr(2, 32'h8000_0100);
    chk("tp1_exec", 64'(pkt[2].execute), 1);
    chk("tp1_td2", 64'(pkt[2].tdata2), 64'h8000_0100);
    rd("tp1_rd", 1, 32'h2000_1044);
    wr(0, 0); wr(1, 0);
    mt(4'b0001, 1, 0);
    chk("tp2_brk", 64'(trig_fire_brk), 1);
    chk("tp2_hit", 64'(trig_hit_vec), 4'b0001);
    rd("tp2_sticky", 1, 32'h2010_0000);
    tick();
    chk("tp2_pulse", 64'(trig_fire_brk), 0);
    rd("tp2_sticky2", 1, 32'h2010_0000);
    wr(1, 32'h0000_0800);
    rd("tp3_chain", 1, 32'h2000_0800);
    wr(0, 1); wr(1, 0);
    mt(0, 0, 4'b0001);
    chk("tp3_alone", 64'(trig_hit_vec), 0);
    mt(0, 0, 4'b0011);
    chk("tp3_pair", 64'(trig_hit_vec), 4'b0011);
    chk("tp3_brk", 64'(trig_fire_brk), 1);
    wr(1, 32'h0000_1000);
    mt(0, 0, 4'b0011);
    chk("tp4_dbg", 64'(trig_fire_dbg), 1);
    chk("tp4_nobrk", 64'(trig_fire_brk), 0);
    mt(0, 0, 4'b0011);
    chk("tp4_masked", 64'({trig_fire_dbg, trig_hit_vec}), 0);
    dbg_mode = 1; tick(); dbg_mode = 0; tick();
    mt(0, 0, 4'b0011);
    chk("tp4_resume", 64'(trig_fire_dbg), 1);
    dbg_mode = 1; tick();
    wr(0, 3); wr(1, 32'h0800_0004);
    dbg_mode = 0; tick();
    wr(2, 32'hFFFF_FFFF);
    rd("tp5_td2", 2, 0);
    wr(1, 0);
    rd("tp5_td1", 1, 32'h2800_0004);
    wr(0, 5);
    rd("tp5_tsel", 0, 3);
    mt(0, 0, 4'b0011);
    chk("tp6_dbg", 64'(trig_fire_dbg), 1);
    lsu = 4'b0011; rst = 1; tick(); rst = 0; lsu = 0;
    chk("tp6_rst", 64'({trig_fire_dbg, trig_fire_brk, trig_hit_vec}), 0);
    mt(0, 0, 4'b0001);
    chk("tp6_armed", 64'(trig_fire_brk), 1);
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      csr_wr_en = $urandom_range(0, 2) == 0;
      csr_wr_sel = 2'($urandom);
      csr_wdata = $urandom_range(0, 1) ? 32'($urandom_range(0, 4)) : $urandom;
      csr_rd_sel = 2'($urandom);
      if ($urandom_range(0, 19) == 0) dbg_mode = ~dbg_mode;
      i0_commit = 1'($urandom);
      dec = 4'($urandom);
      lsu = 4'($urandom & $urandom);
      tick();
    end
    rst = 0; csr_wr_en = 0; dec = 0; lsu = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/el2_dec_trigger_ctl.md
# el2_dec_trigger_ctl

Trigger-register controller for the EL2 core's four hardware triggers. It owns the tselect/tdata1/tdata2 CSR state and builds `trigger_pkt_any[3:0]` for the decode and LSU trigger-match logic. It also folds the raw per-trigger matches back into sticky hit bits, chain qualification and a registered debug/breakpoint action. It sits between the CSR write/read path in the TLU and the match comparators.

## Interface
Parameters:
- NTRIG, 4, number of triggers; fixed at 4 for EL2.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- csr_wr_en  in  1  CSR write strobe, one cycle.
- csr_wr_sel  in  2  write target: 0 tselect, 1 tdata1, 2 tdata2; 3 ignored.
- csr_wdata  in  32  write data.
- csr_rd_sel  in  2  read target (same encoding).
- csr_rdata  out  32  combinational read of the selected register, or 0 for code 3.
- dbg_mode  in  1  core is in debug mode.
- i0_commit  in  1  instruction in decode commits this cycle; qualifies i0 matches.
- dec_i0_trigger_match_d  in  4  raw execute matches from decode.
- lsu_trigger_match_m  in  4  raw load/store matches from the LSU.
- trigger_pkt_any  out  4×el2_trigger_pkt_t  select/match/store/load/execute/m/tdata2 per trigger, driven straight from flops.
- trig_fire_dbg  out  1  registered: enter debug mode (action=1).
- trig_fire_brk  out  1  registered: raise breakpoint exception (action=0).
- trig_hit_vec  out  4  registered per-trigger fire vector, same cycle as the fire outputs.

## Operation
- tdata1 fields used: dmode[27], hit[20], select[19], action[12], chain[11], match[7], m[6], execute[2], store[1], load[0]. type[31:28] reads 4'h2. All other bits read 0.
- tselect write: it takes csr_wdata[1:0] only if csr_wdata[31:2]==0; otherwise it keeps its old value.
- tdata1/tdata2 writes target the trigger selected by tselect. If that trigger's dmode=1 and dbg_mode=0, the write is dropped. dmode itself can be written to 1 only when dbg_mode=1.
- chain is writable only on triggers 0 and 2; it reads 0 on triggers 1 and 3.
- Raw match for trigger i = (dec_i0_trigger_match_d[i] & i0_commit) | lsu_trigger_match_m[i].
- Chain qualification:
  - If chain[0]=1, triggers 0 and 1 each fire only when both raw-match in the same cycle. Same rule for the pair 2/3.
  - An unchained trigger fires on its own raw match.
- Action of a fired pair is taken from the higher-index trigger.
- A fire sets the trigger's sticky hit bit. A fire on any trigger with action=1 asserts trig_fire_dbg; with action=0 it asserts trig_fire_brk. Both can assert in the same cycle.
- A same-cycle CSR write to tdata1 and hit set on the same trigger: the written value is stored, then the hit bit is ORed in. Hit wins.
- FSM, three states:
  - ARMED: fires enabled. Any fire with action=1 → HALT_PEND.
  - HALT_PEND: all fires masked. dbg_mode=1 → DEBUG.
  - DEBUG: all fires masked. dbg_mode=0 → ARMED.
  - dbg_mode=1 seen in ARMED → DEBUG directly.
  - action=0 fires do not leave ARMED.

## Timing
- Reset values:
  - tselect=0.
  - All tdata1 fields 0, so trigger_pkt_any execute/load/store are 0.
  - All tdata2 = 0.
  - FSM = ARMED.
  - trig_fire_dbg, trig_fire_brk and trig_hit_vec = 0.
- A CSR write becomes visible on csr_rdata and trigger_pkt_any in cycle N+1.
- Fire latency: matches in cycle N → trig_fire_* and trig_hit_vec in cycle N+1 for exactly one cycle. The hit bit reads 1 from cycle N+1.
- Fires after a dbg fire are suppressed from cycle N+1, so at most one trig_fire_dbg pulse per HALT_PEND entry.
- Reset asserted mid-HALT_PEND returns to ARMED next cycle with outputs 0.

## Structure
- The following go in el2_pkg: tdata1 bit-position constants, the FSM state enum, and the csr_wr_sel encodings. Reuse the existing el2_trigger_pkt_t.
- One sub-module, el2_trig_reg: per-trigger tdata1/tdata2 flops with the write-lock and hit-set logic, instantiated NTRIG times.
- Chain qualification, the FSM and the read mux live in the top.

## Test plan
- Write tselect=2, then tdata1 with execute=1, m=1, action=1, then tdata2=0x8000_0100 → trigger_pkt_any[2].execute=1 and tdata2=0x8000_0100 next cycle; `csr_rdata` for code 1 reads 0x2000_1044.
- Trigger 0 unchained, action=0; drive dec_i0_trigger_match_d=4'b0001 with i0_commit=1 → trig_fire_brk=1 and trig_hit_vec=4'b0001 one cycle later; hit[20] of trigger 0 stays 1 until tdata1 is rewritten.
- chain[0]=1; match trigger 0 alone → no fire; match triggers 0 and 1 together → trig_hit_vec=4'b0011, action taken from trigger 1.
- Trigger 1 action=1 fires → trig_fire_dbg pulses once. Further matches in HALT_PEND give no output. dbg_mode=1 then 0 → ARMED, and fires resume.
- Set dmode=1 on trigger 3 in debug, exit debug, write tdata2=0xFFFF_FFFF → tdata2 unchanged; tselect write 0x5 → tselect stays 3.
- Assert rst mid-HALT_PEND with pending matches → all outputs 0 and FSM ARMED next cycle.
